// File: rtl/apb_dpmem_param_if.sv
// Bus bundle for apb_dpmem_param: APB4 slave port A plus the native port B
// used by a local engine. Signal names follow the APB and port B pin names.
interface apb_dpmem_param_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
);
    localparam int BAW = $clog2(DEPTH);

    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    logic                    b_en;
    logic                    b_we;
    logic [BAW-1:0]          b_addr;
    logic [DATA_WIDTH-1:0]   b_wdata;
    logic [DATA_WIDTH-1:0]   b_rdata;
    logic                    b_rvalid;
    logic                    b_collision;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR,
        input  b_en, b_we, b_addr, b_wdata,
        output b_rdata, b_rvalid, b_collision
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR,
        output b_en, b_we, b_addr, b_wdata,
        input  b_rdata, b_rvalid, b_collision
    );
endinterface

// File: rtl/apb_dpmem_param.sv
// Dual-port word memory: APB4 slave (strobes, wait states, PSLVERR) on port A,
// single-cycle native read/write on port B. APB wins same-word write collisions.
module apb_dpmem_param #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input logic              PCLK,
    input logic              PRESETn,
    apb_dpmem_param_if.slave bus
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int BAW    = $clog2(DEPTH);

    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $fatal(1, "apb_dpmem_param: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (DEPTH < 2 || (IDX_W < 31 && DEPTH > (1 << IDX_W))) begin : g_bad_depth
        $fatal(1, "apb_dpmem_param: DEPTH out of range for ADDR_WIDTH");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $fatal(1, "apb_dpmem_param: WAIT_STATES must be 0..15");
    end

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
    localparam logic [IDX_W:0]        DEPTH_IDX  = (IDX_W + 1)'(DEPTH);
    localparam logic [BAW:0]          DEPTH_B    = (BAW + 1)'(DEPTH);
    localparam logic [3:0]            WS_INIT    = 4'(WAIT_STATES);

    // The APB setup phase is recognised while IDLE, so a zero-wait transfer
    // completes in the bus's second cycle.
    typedef enum logic {S_IDLE, S_ACCESS} state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q;
    logic                  b_rvalid_q;
    logic                  b_coll_q;

    logic [IDX_W-1:0] a_idx;
    logic [BAW-1:0]   a_word;
    logic             a_err, a_active, a_setup, a_complete, a_load, a_wr;
    logic             b_in_range, b_wr, b_drop;

    assign a_idx      = bus.PADDR[ADDR_WIDTH-1:LSB];
    assign a_word     = a_idx[BAW-1:0];
    assign a_err      = (|(bus.PADDR & ALIGN_MASK)) || ({1'b0, a_idx} >= DEPTH_IDX);
    assign a_active   = bus.PSEL && bus.PENABLE;
    assign a_setup    = bus.PSEL && !bus.PENABLE;
    assign a_complete = (state_q == S_ACCESS) && (cnt_q == 4'd0) && a_active;
    assign a_wr       = a_complete && bus.PWRITE && !a_err;

    // NOTE: every variable gets its default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_load  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (a_setup) begin
                    state_d = S_ACCESS;
                    cnt_d   = WS_INIT;
                    a_load  = (WS_INIT == 4'd0);
                end
            end
            S_ACCESS: begin
                if (!a_active) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d  = cnt_q - 4'd1;
                    a_load = (cnt_q == 4'd1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data is captured on the edge entering the completion cycle.
    always_comb begin
        prdata_d = '0;
        if (a_load && !bus.PWRITE && !a_err) prdata_d = mem[a_word];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prdata_q <= prdata_d;
        end
    end

    assign b_in_range = ({1'b0, bus.b_addr} < DEPTH_B);
    assign b_wr       = bus.b_en && bus.b_we && b_in_range;
    assign b_drop     = b_wr && a_wr && (bus.b_addr == a_word);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            b_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_coll_q   <= 1'b0;
        end else begin
            b_rvalid_q <= bus.b_en && !bus.b_we;
            b_coll_q   <= b_drop;
            if (bus.b_en && !bus.b_we) b_rdata_q <= b_in_range ? mem[bus.b_addr] : '0;
        end
    end

    // NOTE: the array has no reset; contents persist across PRESETn.
    always_ff @(posedge PCLK) begin
        if (a_wr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (bus.PSTRB[i]) mem[a_word][i*8 +: 8] <= bus.PWDATA[i*8 +: 8];
            end
        end
        if (b_wr && !b_drop) mem[bus.b_addr] <= bus.b_wdata;
    end

    assign bus.PREADY      = a_complete;
    assign bus.PSLVERR     = a_complete && a_err;
    assign bus.PRDATA      = prdata_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.b_rvalid    = b_rvalid_q;
    assign bus.b_collision = b_coll_q;
endmodule

// File: doc/apb_dpmem_param.md
Name: apb_dpmem_param

Overview:
- Next-generation APB slave dual-port memory, replacing the fixed-size `apb` slave.
- Port A is an APB4 slave with parametrised width, depth and wait states, byte strobes, and PSLVERR on bad accesses.
- Port B is a native synchronous read/write port for a local engine (DMA/test logic).
- Sits behind apb_if in the top-level bench and SoC fabric.

Parameters:
- ADDR_WIDTH, 12, PADDR width in bits (byte address).
- DATA_WIDTH, 32, data width; one of 8/16/32/64.
- DEPTH, 256, number of words; must be ≤ 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 0, PREADY-low cycles inserted in each APB access phase (0..15).

Ports:
- PCLK  in  1  clock; all logic rising-edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte write strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error; qualified by PREADY.
- b_en  in  1  port B request.
- b_we  in  1  port B write.
- b_addr  in  $clog2(DEPTH)  port B word index.
- b_wdata  in  DATA_WIDTH  port B write data.
- b_rdata  out  DATA_WIDTH  port B read data.
- b_rvalid  out  1  b_rdata valid.
- b_collision  out  1  port B write dropped due to collision.

Behaviour:
- Reset (PRESETn low, asynchronous): FSM returns to IDLE, wait counter is cleared, and PRDATA, PREADY, PSLVERR, b_rdata, b_rvalid and b_collision are all 0. Memory array is not reset; contents are undefined at power-up and retained across reset. Reset mid-transfer abandons the transfer with no write committed.
- FSM states:
  - IDLE: PSEL=1, PENABLE=0 -> SETUP.
  - SETUP: one cycle; wait counter loaded with WAIT_STATES; -> ACCESS.
  - ACCESS: PREADY=0 while counter>0, decrementing each cycle. When counter=0, PREADY=1 for exactly one cycle and the transfer completes; then -> SETUP if PSEL=1 and PENABLE=0 (back-to-back), else IDLE.
  - PSEL dropped in ACCESS before completion: abort, -> IDLE, no write.
  - PENABLE=1 in IDLE (protocol violation): ignored.
- Address decode:
  - LSB = log2(DATA_WIDTH/8); word index = PADDR[ADDR_WIDTH-1:LSB].
  - Error if PADDR[LSB-1:0] != 0 (misaligned) or index ≥ DEPTH.
  - On error: PSLVERR=1 in the completion cycle, PRDATA=0, no write. PSLVERR=0 in all other cycles.
- APB write: committed at the completion-cycle clock edge. Byte i is updated only where PSTRB[i]=1; PSTRB=0 is a legal no-op write that returns no error.
- APB read: PRDATA holds mem[index] during the completion cycle and is 0 otherwise. Data is sampled at the edge entering the completion cycle, so a port B write on that same edge is not visible.
- Port B:
  - Single-cycle requests.
  - Read: b_rdata = mem[b_addr] and b_rvalid=1 on the next cycle; b_rvalid is otherwise 0 and b_rdata holds its last value.
  - Write: committed at the edge where b_en=b_we=1.
  - b_addr ≥ DEPTH: write ignored, read returns 0 with b_rvalid=1.
- Collisions: if port B and an APB write commit to the same word on the same edge, APB wins, the port B write is dropped, and b_collision=1 for one cycle. Same-word writes on different edges are ordered as issued.
- Elaboration fails if DATA_WIDTH is illegal or DEPTH is out of range.

Test Plan:
- Defaults, WAIT_STATES=0. APB write 0xA5A5_1234 to 0x010 with PSTRB=4'hF, then read 0x010 -> PRDATA=0xA5A5_1234 with PREADY in the 2nd cycle of each transfer, PSLVERR=0.
- WAIT_STATES=3. Read 0x010 -> PREADY low for 3 access-phase cycles, then high for 1 cycle with correct data; back-to-back writes have no idle gap.
- Partial strobes: word holds 0xFFFF_FFFF; write 0x0000_0000 with PSTRB=4'b0101 -> readback 0xFF00_FF00.
- Errors: read 0x013 (misaligned) and 0x400 (index 256 ≥ DEPTH) -> PSLVERR=1, PRDATA=0, memory unchanged; next valid transfer has PSLVERR=0.
- Port B: write 0xDEAD_BEEF at index 4, then APB read 0x010 -> 0xDEAD_BEEF. APB write 0x1111_1111 to 0x010 while port B writes index 4 on the same edge -> b_collision pulses, word = 0x1111_1111.
- PRESETn pulsed low mid-ACCESS with WAIT_STATES=2 -> PREADY, PSLVERR and PRDATA go 0 immediately and the pending write is not committed.
